// File: rtl/mem_copy_master.sv
// mem_copy_master: word-granular block-copy initiator on the native picorv32
// memory interface. Each word is a read then a write, with mem_valid dropped
// for one cycle after every handshake.
module mem_copy_master #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_GAP_R,
    S_WR,
    S_GAP_W
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] rem_q;
  logic [LEN_W-1:0] wd_q;
  logic             err_q;
  logic             zdone_q;

  logic             cmd_bad;
  logic             cmd_zero;
  logic             cmd_take;
  logic             hs;

  assign cmd_bad  = (src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00);
  assign cmd_zero = (len_words == '0);
  assign cmd_take = (state == S_IDLE) && start && !cmd_bad && !cmd_zero;
  assign hs       = mem_valid && mem_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cmd_take) state_nxt = S_RD;
      S_RD:    if (mem_ready) state_nxt = S_GAP_R;
      S_GAP_R: state_nxt = S_WR;
      S_WR:    if (mem_ready) state_nxt = S_GAP_W;
      S_GAP_W: state_nxt = (rem_q == '0) ? S_IDLE : S_RD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, address/count progress and status pulse flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      err_q   <= (state == S_IDLE) && start && cmd_bad;
      zdone_q <= (state == S_IDLE) && start && !cmd_bad && cmd_zero;
      if (cmd_take) begin
        src_q <= src_addr;
        dst_q <= dst_addr;
        rem_q <= len_words;
        wd_q  <= '0;
      end else if ((state == S_IDLE) && start && !cmd_bad) begin
        // zero-length command still reports zero words for "last command"
        wd_q <= '0;
      end
      if ((state == S_RD) && hs) begin
        data_q <= mem_rdata;
        src_q  <= src_q + 32'd4;
      end
      if ((state == S_WR) && hs) begin
        dst_q <= dst_q + 32'd4;
        rem_q <= rem_q - LEN_W'(1);
        wd_q  <= wd_q + LEN_W'(1);
      end
    end
  end

  // Bus and status outputs decoded from state
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    busy      = 1'b0;
    done      = zdone_q;
    err       = err_q;
    case (state)
      S_RD: begin
        mem_valid = 1'b1;
        mem_addr  = src_q;
        busy      = 1'b1;
      end
      S_GAP_R: busy = 1'b1;
      S_WR: begin
        mem_valid = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = data_q;
        mem_wstrb = 4'hF;
        busy      = 1'b1;
      end
      S_GAP_W: begin
        busy = 1'b1;
        if (rem_q == '0) done = 1'b1;
      end
      default: ;
    endcase
  end

  assign words_done = wd_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: a table of directed commands, randomized commands
// against a word-copy reference model, and hand sequences for reset abort.
module tb_mem_copy_master;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, err;
  logic [15:0] words_done;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_copy_master #(.LEN_W(16)) dut (
    .clock(clock), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .busy(busy), .done(done), .err(err), .words_done(words_done),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic [31:0] smem    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  txn_t        bus_log [$];
  txn_t        exp_log [$];
  int          lat = 0;
  int          wcnt = 0;
  int          hs_cnt = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_wd = '0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory responder: ready after 'lat' waiting cycles, dropped after handshake
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      wcnt      <= 0;
    end else if (mem_valid && mem_ready) begin
      if (mem_wstrb == 4'hF) smem[mem_addr] = mem_wdata;
      bus_log.push_back('{we: (mem_wstrb != 4'h0), a: mem_addr,
                          d: (mem_wstrb != 4'h0) ? mem_wdata : mem_rdata});
      hs_cnt = hs_cnt + 1;
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end else if (mem_valid) begin
      if (wcnt >= lat) begin
        mem_ready <= 1'b1;
        mem_rdata <= mem_rd(mem_addr);
      end
      wcnt <= wcnt + 1;
    end else begin
      mem_ready <= 1'b0;
      wcnt      <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    foreach (ref_mem[a]) if (!smem.exists(a) || smem[a] !== ref_mem[a]) bad++;
    foreach (smem[a]) if (!ref_mem.exists(a)) bad++;
    check({name, "_mem"}, bad, 0);
  endtask

  task automatic check_log(input string name);
    int bad = 0;
    check({name, "_nxfers"}, bus_log.size(), exp_log.size());
    for (int i = 0; i < bus_log.size() && i < exp_log.size(); i++)
      if (bus_log[i] !== exp_log[i]) begin
        bad++;
        if (bad == 1)
          $display("FAIL %s_xfer%0d: got we=%0b a=%h d=%h expected we=%0b a=%h d=%h",
                   name, i, bus_log[i].we, bus_log[i].a, bus_log[i].d,
                   exp_log[i].we, exp_log[i].a, exp_log[i].d);
      end
    checks++;
    if (bad != 0) errors++;
  endtask

  // Reference: word-by-word ascending copy with 32-bit wrapping addresses
  task automatic model_cmd(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    logic [31:0] v, ra, wa;
    exp_log.delete();
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) return;
    for (int i = 0; i < int'(n); i++) begin
      ra = s + 32'(4 * i);
      wa = d + 32'(4 * i);
      v  = ref_rd(ra);
      exp_log.push_back('{we: 1'b0, a: ra, d: v});
      ref_mem[wa] = v;
      exp_log.push_back('{we: 1'b1, a: wa, d: v});
    end
    last_wd = n;
  endtask

  task automatic run_cmd(input string name, input logic [31:0] s, input logic [31:0] d,
                         input logic [15:0] n, input int l, input bit spam,
                         input int exp_err, input int exp_busy);
    int busy_c = 0, done_c = 0, err_c = 0, cycles = 0, extra = 0;
    int stab_bad = 0, gap_bad = 0;
    bit seen = 0, first = 1;
    logic        pv = 0;
    logic [31:0] pa = '0, pd = '0;
    logic [3:0]  ps = '0;
    int          phs;
    model_cmd(s, d, n);
    bus_log.delete();
    lat = l;
    @(negedge clock);
    src_addr = s; dst_addr = d; len_words = n; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    phs = hs_cnt;
    forever begin
      if (first) begin
        check({name, "_first_busy"}, busy, (exp_busy != 0));
        check({name, "_first_valid"}, mem_valid, (exp_busy != 0));
        first = 0;
      end
      busy_c += busy; done_c += done; err_c += err;
      if (hs_cnt != phs) begin
        if (mem_valid || (hs_cnt - phs) > 1) gap_bad++;
      end else if (pv && mem_valid) begin
        if (mem_addr !== pa || mem_wdata !== pd || mem_wstrb !== ps) stab_bad++;
      end
      if (done || err) seen = 1;
      if (seen && !busy) extra++;
      if (extra > 3) break;
      if (++cycles > 3000) begin
        $display("FAIL %s_timeout: got no completion expected done/err", name);
        errors++;
        break;
      end
      if (spam && busy) begin
        start = 1'($urandom % 2);
        src_addr = $urandom; dst_addr = $urandom; len_words = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      pv = mem_valid; pa = mem_addr; pd = mem_wdata; ps = mem_wstrb; phs = hs_cnt;
      @(negedge clock);
    end
    start = 1'b0;
    checks++;
    check({name, "_err"}, err_c, exp_err);
    check({name, "_done"}, done_c, (exp_err != 0) ? 0 : 1);
    check({name, "_busy_cycles"}, busy_c, exp_busy);
    check({name, "_words_done"}, words_done, last_wd);
    check({name, "_stable"}, stab_bad, 0);
    check({name, "_gap"}, gap_bad, 0);
    check_log(name);
    check_mem(name);
    checks--;
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    int          lat;
    int          exp_err;
    int          exp_busy;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] s, d, v0;
    logic [15:0] n;
    int l, base;

    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 16'd4, 0, 0, 24};
    vecs[1] = '{32'h0000_0102, 32'h0000_0200, 16'd3, 0, 1, 0};
    vecs[2] = '{32'h0000_0100, 32'h0000_0203, 16'd1, 0, 1, 0};
    vecs[3] = '{32'h0000_0100, 32'h0000_0300, 16'd0, 0, 0, 0};
    vecs[4] = '{32'h0000_0100, 32'h0000_0400, 16'd2, 5, 0, 32};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0500, 16'd2, 1, 0, 16};
    vecs[6] = '{32'h0000_0100, 32'h0000_0104, 16'd3, 0, 0, 18};

    for (int i = 0; i < 4; i++) begin
      smem[32'h100 + 32'(4 * i)]    = 32'h1111_1111 * 32'(i + 1);
      ref_mem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
    end

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_valid", mem_valid, 0);
    check("rst_words_done", words_done, 0);
    check("rst_bus", {mem_addr ^ mem_wdata, 28'(0), mem_wstrb}, 0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      run_cmd($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst, vecs[i].len,
              vecs[i].lat, 0, vecs[i].exp_err, vecs[i].exp_busy);

    // start pulses during a copy must not disturb the latched command
    run_cmd("spam", 32'h100, 32'h800, 16'd4, 1, 1, 0, 4 * 8);

    // reset during the second write abandons the copy after word 0
    for (int i = 0; i < 4; i++) begin
      smem[32'h600 + 32'(4 * i)]    = 32'hC0DE_0000 + 32'(i);
      ref_mem[32'h600 + 32'(4 * i)] = 32'hC0DE_0000 + 32'(i);
    end
    v0 = ref_rd(32'h600);
    ref_mem[32'h700] = v0;
    exp_log.delete();
    exp_log.push_back('{we: 1'b0, a: 32'h600, d: v0});
    exp_log.push_back('{we: 1'b1, a: 32'h700, d: v0});
    exp_log.push_back('{we: 1'b0, a: 32'h604, d: ref_rd(32'h604)});
    bus_log.delete();
    lat = 0;
    @(negedge clock);
    src_addr = 32'h600; dst_addr = 32'h700; len_words = 16'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    base = hs_cnt;
    for (int c = 0; c < 100; c++) begin
      if (mem_valid && (hs_cnt - base) == 3) break;
      @(negedge clock);
    end
    check("abort_in_wr2", {31'(hs_cnt - base), mem_wstrb == 4'hF}, {31'd3, 1'b1});
    reset = 1'b1;
    #1;
    check("abort_valid", mem_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_words_done", words_done, 0);
    @(negedge clock);
    reset = 1'b0;
    last_wd = '0;
    repeat (3) @(negedge clock);
    check("abort_idle", {busy, mem_valid}, 0);
    check_log("abort");
    check_mem("abort");

    // randomized commands against the reference model
    for (int k = 0; k < 30; k++) begin
      s = 32'h1000 + 32'(($urandom % 48) * 4);
      d = 32'h1000 + 32'(($urandom % 48) * 4);
      if ($urandom % 6 == 0) s[1:0] = 2'($urandom);
      if ($urandom % 8 == 0) d[1:0] = 2'($urandom);
      n = 16'($urandom % 7);
      l = int'($urandom % 4);
      if (s[1:0] != 0 || d[1:0] != 0)
        run_cmd($sformatf("rnd%0d", k), s, d, n, l, 1'($urandom % 2), 1, 0);
      else
        run_cmd($sformatf("rnd%0d", k), s, d, n, l, 1'($urandom % 2), 0,
                int'(n) * (2 * l + 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Word-granular block-copy engine; acts as initiator on the native picorv32 memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Reads N words from a source address and writes them to a destination address through the same single-port memory.
- Used in the testbench/SoC to preload or move SRAM contents without the CPU.
- Completes with a status pulse.

Parameters:
- LEN_W, 16, width of the word-count command field and progress counter.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- src_addr  in  32  source byte address; must be word-aligned.
- dst_addr  in  32  destination byte address; must be word-aligned.
- len_words  in  LEN_W  number of 32-bit words to copy.
- busy  out  1  high from the cycle after an accepted start until done/err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on a rejected (misaligned) command.
- words_done  out  LEN_W  count of words written for the current/last command.
- mem_valid  out  1  request valid.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  request address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes; 0 = read, 4'hF = write.
- mem_rdata  in  32  read data; valid in the handshake cycle.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and remaining-count registers 0. Asserting reset mid-transfer drops mem_valid immediately (asynchronous). The partially completed copy is abandoned.
- Handshake:
  - A transfer completes on a rising edge where mem_valid && mem_ready.
  - While mem_valid is high, mem_addr, mem_wdata and mem_wstrb are held stable.
  - mem_valid is low for exactly one cycle after every handshake, so responders that toggle ready each cycle see a clean edge.
  - mem_ready while mem_valid is low is ignored.
- States:
  - IDLE: busy=0.
    - start with src_addr[1:0]!=0 or dst_addr[1:0]!=0: err pulse next cycle; stay IDLE; no bus activity.
    - start with len_words==0: done pulse next cycle; no bus activity.
    - Otherwise: latch src, dst, len; clear words_done; go to RD.
  - RD: mem_valid=1, mem_wstrb=0, mem_addr=src. On handshake, capture mem_rdata into the data register, src+=4, go to GAP_R.
  - GAP_R: mem_valid=0; go to WR.
  - WR: mem_valid=1, mem_wstrb=4'hF, mem_addr=dst, mem_wdata=captured data. On handshake, dst+=4, remaining-=1, words_done+=1, go to GAP_W.
  - GAP_W: mem_valid=0.
    - remaining==0: go to IDLE, assert done for this one cycle.
    - Otherwise: go to RD.
- busy is 1 in RD, GAP_R, WR and GAP_W.
- start while busy is ignored; the latched command is unaffected.
- Address arithmetic is 32-bit modulo: wraps from 0xFFFFFFFC to 0x00000000 with no error.
- Overlapping regions are copied strictly in ascending order, one word at a time; no overlap detection.
- Latency: start sampled at edge T ⇒ first mem_valid at T+1. Against a responder with 1-cycle ready, each word takes 6 cycles: RD×2, GAP_R, WR×2, GAP_W.
- mem_valid stalls indefinitely while mem_ready stays low; there is no timeout.
- done and err never assert together. words_done holds its value after completion until the next accepted start.

Test Plan:
- Preload SRAM words 0x100..0x10C = 0x11111111..0x44444444; start src=0x100, dst=0x200, len=4 ⇒ words at 0x200..0x20C match; done pulses once; words_done=4; busy high for 24 cycles.
- start src=0x102, dst=0x200, len=3 ⇒ err pulse one cycle later; mem_valid never asserts; SRAM unchanged.
- len=0 ⇒ done pulse, no mem_valid, words_done=0.
- Responder with ready delayed 5 cycles ⇒ addr/wdata/wstrb stable throughout each valid window; data still correct.
- Assert reset during the second WR of a 4-word copy ⇒ mem_valid low the same cycle; busy=0; only word 0 written at dst.
- start pulses during busy ⇒ ignored; copy completes with the original parameters. Wrap case: src=0xFFFFFFFC, len=2 ⇒ second read at 0x00000000.
